// File: rtl/ldl_rr_pri_pkt.sv
// Multi-class round-robin arbiter with packet locking and starvation aging.
// Outputs are combinational from registered state and inputs (zero latency).
module ldl_rr_pri_pkt #(
  parameter  int unsigned BIN_WIDTH = 3,
  parameter  int unsigned COS_WIDTH = 2,
  parameter  int unsigned AGE_MAX   = 4,
  localparam int unsigned REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REQ_WIDTH-1:0]                req,
  input  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] icos,
  input  logic [REQ_WIDTH-1:0]                last,
  input  logic                                ready,
  output logic                                valid,
  output logic [BIN_WIDTH-1:0]                bin,
  output logic [COS_WIDTH-1:0]                ocos,
  output logic                                promo,
  output logic [REQ_WIDTH-1:0]                ack
);

  localparam int unsigned COS_NUM = 1 << COS_WIDTH;
  localparam int unsigned AGE_W   = (AGE_MAX < 2) ? 1 : $clog2(AGE_MAX + 1);

  typedef enum logic {ARB, LOCK} state_t;

  state_t                                 state_q, state_d;
  logic [COS_NUM-1:0][BIN_WIDTH-1:0]      ptr_q, ptr_d;
  logic [REQ_WIDTH-1:0][AGE_W-1:0]        age_q, age_d;
  logic [BIN_WIDTH-1:0]                   lidx_q, lidx_d;
  logic [COS_WIDTH-1:0]                   lcos_q, lcos_d;
  logic [COS_WIDTH-1:0]                   lecos_q, lecos_d;
  logic                                   lpromo_q, lpromo_d;

  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0]    ecos;
  logic [COS_WIDTH-1:0]                   maxc;
  logic [COS_WIDTH-1:0]                   use_cls;
  logic [BIN_WIDTH-1:0]                   arb_win;
  logic [BIN_WIDTH-1:0]                   idx;
  logic                                   arb_found;
  logic                                   xfer;
  logic                                   pkt_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      age_q    <= '0;
      lidx_q   <= '0;
      lcos_q   <= '0;
      lecos_q  <= '0;
      lpromo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      age_q    <= age_d;
      lidx_q   <= lidx_d;
      lcos_q   <= lcos_d;
      lecos_q  <= lecos_d;
      lpromo_q <= lpromo_d;
    end
  end

  always_comb begin
    ecos      = icos;
    maxc      = '0;
    use_cls   = '0;
    arb_win   = '0;
    idx       = '0;
    arb_found = 1'b0;
    valid     = 1'b0;
    bin       = '0;
    ocos      = '0;
    promo     = 1'b0;
    state_d   = state_q;
    ptr_d     = ptr_q;
    age_d     = age_q;
    lidx_d    = lidx_q;
    lcos_d    = lcos_q;
    lecos_d   = lecos_q;
    lpromo_d  = lpromo_q;

    // A waiter that has sat out AGE_MAX packets competes at the top class
    for (int i = 0; i < int'(REQ_WIDTH); i++) begin
      if (AGE_MAX != 0 && age_q[i] == AGE_W'(AGE_MAX)) ecos[i] = '1;
    end
    for (int i = 0; i < int'(REQ_WIDTH); i++) begin
      if (req[i] && ecos[i] > maxc) maxc = ecos[i];
    end
    // Rotating search from the pointer of the winning class
    for (int k = 0; k < int'(REQ_WIDTH); k++) begin
      idx = ptr_q[maxc] + BIN_WIDTH'(k);
      if (!arb_found && req[idx] && ecos[idx] == maxc) begin
        arb_found = 1'b1;
        arb_win   = idx;
      end
    end

    if (rst) begin
      if (state_q == LOCK) begin
        valid   = req[lidx_q];
        bin     = lidx_q;
        ocos    = lcos_q;
        promo   = lpromo_q;
        use_cls = lecos_q;
      end else if (|req) begin
        valid   = 1'b1;
        bin     = arb_win;
        ocos    = icos[arb_win];
        promo   = (ecos[arb_win] != icos[arb_win]);
        use_cls = maxc;
      end
    end

    xfer    = valid & ready;
    pkt_end = xfer & last[bin];
    ack     = xfer ? (REQ_WIDTH'(1) << bin) : '0;

    for (int i = 0; i < int'(REQ_WIDTH); i++) begin
      if (!req[i]) begin
        age_d[i] = '0;
      end else if (pkt_end) begin
        if (BIN_WIDTH'(i) == bin) age_d[i] = '0;
        else if (age_q[i] < AGE_W'(AGE_MAX)) age_d[i] = age_q[i] + AGE_W'(1);
      end
    end

    if (pkt_end) begin
      ptr_d[use_cls] = bin + BIN_WIDTH'(1);
      state_d        = ARB;
    end else if (xfer && state_q == ARB) begin
      state_d  = LOCK;
      lidx_d   = bin;
      lcos_d   = icos[bin];
      lecos_d  = maxc;
      lpromo_d = promo;
    end
  end

endmodule
